// File: rtl/ysyx_24080006_icache_ctrl_if.sv
// I-cache controller bus bundle: IFU fetch port, line-SRAM port, AXI read channel, counters.
interface ysyx_24080006_icache_ctrl_if #(
  parameter int unsigned IC_N       = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
);
  localparam int unsigned OFF   = $clog2(LINE_WORDS * 4);
  localparam int unsigned TAG_W = ADDR_W - OFF - IC_N;

  // IFU fetch port
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_inst;
  logic                    resp_err;
  logic                    fence_i;
  // line SRAM port
  logic [IC_N-1:0]         ic_index;
  logic                    ic_we;
  logic                    ic_wvalid;
  logic [TAG_W-1:0]        ic_wtag;
  logic [32*LINE_WORDS-1:0] ic_wline;
  logic                    ic_rvalid;
  logic [TAG_W-1:0]        ic_rtag;
  logic [32*LINE_WORDS-1:0] ic_rline;
  // AXI read channel
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_W-1:0]       araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    rvalid;
  logic                    rready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  // statistics
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;

  modport master (
    input  req_valid, req_addr, resp_ready, fence_i,
           ic_rvalid, ic_rtag, ic_rline,
           arready, rvalid, rdata, rresp, rlast,
    output req_ready, resp_valid, resp_inst, resp_err,
           ic_index, ic_we, ic_wvalid, ic_wtag, ic_wline,
           arvalid, araddr, arlen, arsize, arburst, rready,
           hit_cnt, miss_cnt
  );

  modport slave (
    output req_valid, req_addr, resp_ready, fence_i,
           ic_rvalid, ic_rtag, ic_rline,
           arready, rvalid, rdata, rresp, rlast,
    input  req_ready, resp_valid, resp_inst, resp_err,
           ic_index, ic_we, ic_wvalid, ic_wtag, ic_wline,
           arvalid, araddr, arlen, arsize, arburst, rready,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/ysyx_24080006_icache_ctrl.sv
// I-cache sequencer: tag lookup, line refill over AXI burst, SRAM write-back, full invalidation.
module ysyx_24080006_icache_ctrl #(
  parameter int unsigned IC_N       = 4,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_24080006_icache_ctrl_if.master   bus
);
  localparam int unsigned OFF    = $clog2(LINE_WORDS * 4);
  localparam int unsigned WORD_W = OFF - 2;
  localparam int unsigned TAG_W  = ADDR_W - OFF - IC_N;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOOKUP, S_AR, S_RFILL, S_WRITE, S_RESP
  } state_e;

  state_e                         state_q, state_d;
  logic [IC_N-1:0]                sweep_q, sweep_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [WORD_W-1:0]              beat_q, beat_d;
  logic                           err_q, err_d;
  logic [LINE_WORDS-1:0][31:0]    buf_q, buf_d;
  logic                           fence_pend_q, fence_pend_d;
  logic [31:0]                    hit_cnt_q, hit_cnt_d;
  logic [31:0]                    miss_cnt_q, miss_cnt_d;
  logic [31:0]                    resp_inst_q, resp_inst_d;
  logic                           resp_err_q, resp_err_d;

  logic [TAG_W-1:0]               tag;
  logic [IC_N-1:0]                idx;
  logic [WORD_W-1:0]              word;
  logic                           misaligned;
  logic                           hit;
  logic [LINE_WORDS-1:0][31:0]    rline;

  // Fields of the latched fetch address
  assign tag        = addr_q[ADDR_W-1 -: TAG_W];
  assign idx        = addr_q[OFF +: IC_N];
  assign word       = addr_q[2 +: WORD_W];
  assign misaligned = addr_q[1:0] != 2'b00;
  assign rline      = bus.ic_rline;
  assign hit        = bus.ic_rvalid && (bus.ic_rtag == tag);

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FLUSH;
      sweep_q      <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      buf_q        <= '0;
      fence_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      resp_inst_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      buf_q        <= buf_d;
      fence_pend_q <= fence_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      resp_inst_q  <= resp_inst_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    err_d        = err_q;
    buf_d        = buf_q;
    fence_pend_d = fence_pend_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    resp_inst_d  = resp_inst_q;
    resp_err_d   = resp_err_q;

    // A fence seen while busy is remembered and serviced from IDLE
    if (bus.fence_i && (state_q != S_IDLE)) fence_pend_d = 1'b1;

    unique case (state_q)
      S_FLUSH: begin
        sweep_d = sweep_q + IC_N'(1);
        if (&sweep_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.fence_i || fence_pend_q) begin
          fence_pend_d = 1'b0;
          sweep_d      = '0;
          state_d      = S_FLUSH;
        end else if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (misaligned) begin
          resp_inst_d = '0;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else if (hit) begin
          resp_inst_d = rline[word];
          resp_err_d  = 1'b0;
          hit_cnt_d   = hit_cnt_q + 32'd1;
          state_d     = S_RESP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          err_d      = 1'b0;
          beat_d     = '0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (bus.arready) state_d = S_RFILL;
      end
      S_RFILL: begin
        if (bus.rvalid) begin
          buf_d[beat_q] = bus.rdata;
          beat_d        = beat_q + WORD_W'(1);
          if (bus.rresp != 2'b00) err_d = 1'b1;
          if (bus.rlast != (&beat_q)) err_d = 1'b1;
          if (bus.rlast) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        resp_inst_d = buf_q[word];
        resp_err_d  = err_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // Outputs decoded from registered state
  assign bus.req_ready  = (state_q == S_IDLE) && !fence_pend_q;
  assign bus.resp_valid = state_q == S_RESP;
  assign bus.resp_inst  = resp_inst_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ic_index   = (state_q == S_FLUSH) ? sweep_q : idx;
  assign bus.ic_we      = (state_q == S_FLUSH) || ((state_q == S_WRITE) && !err_q);
  assign bus.ic_wvalid  = (state_q == S_WRITE) && !err_q;
  assign bus.ic_wtag    = tag;
  assign bus.ic_wline   = buf_q;
  assign bus.arvalid    = state_q == S_AR;
  assign bus.araddr     = {tag, idx, OFF'(0)};
  assign bus.arlen      = 8'(LINE_WORDS - 1);
  assign bus.arsize     = 3'b010;
  assign bus.arburst    = 2'b01;
  assign bus.rready     = state_q == S_RFILL;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_24080006_icache_ctrl.sv
// Directed bench for the I-cache controller with a behavioural line SRAM and AXI driver.
module tb_ysyx_24080006_icache_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int ar_cnt   = 0;

  logic [3:0][31:0] line_a = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
  logic [3:0][31:0] line_b = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
  logic [3:0][31:0] line_c = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
  logic [3:0][31:0] line_d = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};

  ysyx_24080006_icache_ctrl_if #(.IC_N(4), .LINE_WORDS(4), .ADDR_W(32)) bus ();

  ysyx_24080006_icache_ctrl #(.IC_N(4), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Line SRAM model, preloaded with lines that would falsely hit if never invalidated
  logic         m_v [16];
  logic [23:0]  m_t [16];
  logic [127:0] m_l [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b1;
      m_t[i] = 24'h800000;
      m_l[i] = {4{32'hDEAD_BEEF}};
    end
  end
  always @(posedge clock) begin
    if (bus.ic_we) begin
      m_v[bus.ic_index] <= bus.ic_wvalid;
      m_t[bus.ic_index] <= bus.ic_wtag;
      m_l[bus.ic_index] <= bus.ic_wline;
    end
  end
  assign bus.ic_rvalid = m_v[bus.ic_index];
  assign bus.ic_rtag   = m_t[bus.ic_index];
  assign bus.ic_rline  = m_l[bus.ic_index];

  // Event counters for SRAM writes and AR handshakes
  always @(posedge clock) begin
    if (bus.ic_we) we_cnt <= we_cnt + 1;
    if (bus.arvalid && bus.arready) ar_cnt <= ar_cnt + 1;
  end

  task automatic send_req(input logic [31:0] a);
    int n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clock); n++; end
    if (!bus.req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    while (!bus.arvalid && n < 20) begin @(negedge clock); n++; end
    if (!bus.arvalid) begin
      n_checks++; n_fail++;
      $display("FAIL arvalid_timeout: got 0 expected 1");
    end
  endtask

  task automatic ar_accept();
    bus.arready = 1'b1;
    @(negedge clock);
    bus.arready = 1'b0;
  endtask

  task automatic resp_accept();
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic serve_fill(input logic [3:0][31:0] d, input logic [3:0][1:0] rr,
                            input logic [3:0] last, input bit fence_pulse);
    for (int b = 0; b < 4; b++) begin
      int n = 0;
      while (!bus.rready && n < 50) begin @(negedge clock); n++; end
      if (!bus.rready) begin
        n_checks++; n_fail++;
        $display("FAIL rready_timeout: got 0 expected 1 at beat %0d", b);
      end
      bus.rvalid  = 1'b1;
      bus.rdata   = d[b];
      bus.rresp   = rr[b];
      bus.rlast   = last[b];
      bus.fence_i = fence_pulse && (b == 0);
      @(negedge clock);
      bus.fence_i = 1'b0;
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b expected 0", bus.arvalid); end
    n_checks++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b expected 0", bus.rready); end
    n_checks++; if (bus.hit_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_hit_cnt: got %0d expected 0", bus.hit_cnt); end
    n_checks++; if (bus.miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_miss_cnt: got %0d expected 0", bus.miss_cnt); end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_req_ready[%0d]: got %b expected 0", i, bus.req_ready); end
      n_checks++; if (bus.ic_we !== 1'b1) begin n_fail++; $display("FAIL flush_we[%0d]: got %b expected 1", i, bus.ic_we); end
      n_checks++; if (bus.ic_wvalid !== 1'b0) begin n_fail++; $display("FAIL flush_wvalid[%0d]: got %b expected 0", i, bus.ic_wvalid); end
      n_checks++; if (bus.ic_index !== 4'(i)) begin n_fail++; $display("FAIL flush_index[%0d]: got %0d expected %0d", i, bus.ic_index, i); end
      @(negedge clock);
    end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_done_req_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (bus.ic_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b expected 0", bus.ic_we); end
  endtask

  task automatic test_cold_miss();
    send_req(32'h8000_0004);
    n_checks++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL cold_lookup_arvalid: got %b expected 0", bus.arvalid); end
    @(negedge clock);
    n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL cold_arvalid: got %b expected 1", bus.arvalid); end
    n_checks++; if (bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL cold_araddr: got %h expected 80000000", bus.araddr); end
    n_checks++; if (bus.arlen !== 8'd3) begin n_fail++; $display("FAIL cold_arlen: got %0d expected 3", bus.arlen); end
    n_checks++; if (bus.arsize !== 3'b010) begin n_fail++; $display("FAIL cold_arsize: got %b expected 010", bus.arsize); end
    n_checks++; if (bus.arburst !== 2'b01) begin n_fail++; $display("FAIL cold_arburst: got %b expected 01", bus.arburst); end
    n_checks++; if (bus.miss_cnt !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt: got %0d expected 1", bus.miss_cnt); end
    @(negedge clock);
    n_checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL cold_ar_hold: got %b/%h expected 1/80000000", bus.arvalid, bus.araddr); end
    ar_accept();
    serve_fill(line_a, '0, 4'b1000, 1'b0);
    n_checks++; if (bus.ic_we !== 1'b1 || bus.ic_wvalid !== 1'b1) begin n_fail++; $display("FAIL cold_write_strobe: got %b%b expected 11", bus.ic_we, bus.ic_wvalid); end
    n_checks++; if (bus.ic_index !== 4'd0) begin n_fail++; $display("FAIL cold_write_index: got %0d expected 0", bus.ic_index); end
    n_checks++; if (bus.ic_wtag !== 24'h800000) begin n_fail++; $display("FAIL cold_write_tag: got %h expected 800000", bus.ic_wtag); end
    n_checks++; if (bus.ic_wline !== 128'(line_a)) begin n_fail++; $display("FAIL cold_write_line: got %h expected %h", bus.ic_wline, line_a); end
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL cold_resp_valid: got %b expected 1", bus.resp_valid); end
    n_checks++; if (bus.resp_inst !== line_a[1]) begin n_fail++; $display("FAIL cold_resp_inst: got %h expected %h", bus.resp_inst, line_a[1]); end
    n_checks++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL cold_resp_err: got %b expected 0", bus.resp_err); end
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_inst !== line_a[1]) begin n_fail++; $display("FAIL cold_resp_hold: got %b/%h expected 1/%h", bus.resp_valid, bus.resp_inst, line_a[1]); end
    resp_accept();
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL cold_resp_drop: got %b expected 0", bus.resp_valid); end
  endtask

  task automatic test_hit();
    int ar0 = ar_cnt;
    send_req(32'h8000_000C);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_early_resp: got %b expected 0", bus.resp_valid); end
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL hit_resp_valid: got %b expected 1", bus.resp_valid); end
    n_checks++; if (bus.resp_inst !== line_a[3]) begin n_fail++; $display("FAIL hit_resp_inst: got %h expected %h", bus.resp_inst, line_a[3]); end
    n_checks++; if (bus.hit_cnt !== 32'd1) begin n_fail++; $display("FAIL hit_cnt: got %0d expected 1", bus.hit_cnt); end
    n_checks++; if (ar_cnt !== ar0 || bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL hit_no_ar: got %0d/%b expected %0d/0", ar_cnt, bus.arvalid, ar0); end
    resp_accept();
  endtask

  task automatic test_bus_error();
    int we0 = we_cnt;
    send_req(32'h8000_0110);
    wait_ar();
    n_checks++; if (bus.araddr !== 32'h8000_0110) begin n_fail++; $display("FAIL err_araddr: got %h expected 80000110", bus.araddr); end
    ar_accept();
    serve_fill(line_b, {2'b00, 2'b00, 2'b10, 2'b00}, 4'b1000, 1'b0);
    n_checks++; if (bus.ic_we !== 1'b0) begin n_fail++; $display("FAIL err_write_we: got %b expected 0", bus.ic_we); end
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL err_resp: got %b/%b expected 1/1", bus.resp_valid, bus.resp_err); end
    resp_accept();
    n_checks++; if (we_cnt !== we0) begin n_fail++; $display("FAIL err_no_write: got %0d writes expected %0d", we_cnt, we0); end
    send_req(32'h8000_0110);
    @(negedge clock);
    n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL err_refetch_miss: got %b expected 1", bus.arvalid); end
    n_checks++; if (bus.miss_cnt !== 32'd3) begin n_fail++; $display("FAIL err_miss_cnt: got %0d expected 3", bus.miss_cnt); end
    ar_accept();
    serve_fill(line_c, '0, 4'b1000, 1'b0);
    @(negedge clock);
    n_checks++; if (bus.resp_inst !== line_c[0] || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL err_refill_resp: got %h/%b expected %h/0", bus.resp_inst, bus.resp_err, line_c[0]); end
    resp_accept();
  endtask

  task automatic test_fence();
    int cnt = 0;
    send_req(32'h8000_0020);
    wait_ar();
    ar_accept();
    serve_fill(line_d, '0, 4'b1000, 1'b1);
    n_checks++; if (bus.ic_we !== 1'b1 || bus.ic_wvalid !== 1'b1 || bus.ic_index !== 4'd2) begin n_fail++; $display("FAIL fence_fill_write: got %b%b idx %0d expected 11 idx 2", bus.ic_we, bus.ic_wvalid, bus.ic_index); end
    @(negedge clock);
    n_checks++; if (bus.resp_inst !== line_d[0]) begin n_fail++; $display("FAIL fence_fill_resp: got %h expected %h", bus.resp_inst, line_d[0]); end
    resp_accept();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL fence_pend_ready: got %b expected 0", bus.req_ready); end
    @(negedge clock);
    while (bus.ic_we && cnt < 40) begin
      if (bus.ic_wvalid !== 1'b0 || bus.req_ready !== 1'b0) cnt = 100;
      cnt++;
      @(negedge clock);
    end
    n_checks++; if (cnt !== 16) begin n_fail++; $display("FAIL fence_sweep_len: got %0d expected 16", cnt); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL fence_done_ready: got %b expected 1", bus.req_ready); end
    send_req(32'h8000_0004);
    @(negedge clock);
    n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL fence_refetch_miss: got %b expected 1", bus.arvalid); end
    n_checks++; if (bus.miss_cnt !== 32'd5) begin n_fail++; $display("FAIL fence_miss_cnt: got %0d expected 5", bus.miss_cnt); end
    ar_accept();
    serve_fill(line_a, '0, 4'b1000, 1'b0);
    @(negedge clock);
    n_checks++; if (bus.resp_inst !== line_a[1]) begin n_fail++; $display("FAIL fence_refetch_inst: got %h expected %h", bus.resp_inst, line_a[1]); end
    resp_accept();
  endtask

  task automatic test_misaligned();
    int ar0 = ar_cnt;
    send_req(32'h8000_0002);
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL mis_resp: got %b/%b expected 1/1", bus.resp_valid, bus.resp_err); end
    n_checks++; if (bus.hit_cnt !== 32'd1 || bus.miss_cnt !== 32'd5) begin n_fail++; $display("FAIL mis_counters: got %0d/%0d expected 1/5", bus.hit_cnt, bus.miss_cnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin n_fail++; $display("FAIL mis_hold[%0d]: got %b/%b expected 1/1", i, bus.resp_valid, bus.resp_err); end
    end
    n_checks++; if (ar_cnt !== ar0) begin n_fail++; $display("FAIL mis_no_ar: got %0d expected %0d", ar_cnt, ar0); end
    resp_accept();
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_release: got %b/%b expected 0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    send_req(32'h8000_0008);
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_inst !== line_a[2]) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/%h", bus.resp_valid, bus.resp_inst, line_a[2]); end
    resp_accept();
    send_req(32'h8000_0000);
    @(negedge clock);
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_inst !== line_a[0]) begin n_fail++; $display("FAIL b2b_second: got %b/%h expected 1/%h", bus.resp_valid, bus.resp_inst, line_a[0]); end
    n_checks++; if (bus.hit_cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_hit_cnt: got %0d expected 3", bus.hit_cnt); end
    resp_accept();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.fence_i    = 1'b0;
    bus.arready    = 1'b0;
    bus.rvalid     = 1'b0;
    bus.rdata      = '0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b0;
    #1 reset = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_bus_error();
    test_fence();
    test_misaligned();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
